game_tree_v2: RTL and testbench

- Connect-Four move search: 7 columns x 6 rows, two bitboards ("me", "op") plus per-column heights.
- Sequentially tries every legal column for the side to move and evaluates each resulting position by minimax down to DEPTH plies.
- Outputs the best column and its score, always from "me" perspective.
- Sits between board-state logic and the game controller. DEPTH>1 is realised by a single child instance of itself (DEPTH-1, IS_ME inverted).

---
 rtl/game_tree_v2.sv | 234 +++++++++++++++++++++++
 tb/tb_game_tree_v2.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tree_v2.sv
// Connect-Four minimax move search over a 7x6 board.
// Depth beyond one ply recurses into a single child instance.
module game_tree_v2 #(
    parameter bit IS_ME = 1'b1,
    parameter int DEPTH = 1
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic               w_en,
    input  logic [41:0]        i_me_field,
    input  logic [41:0]        i_op_field,
    input  logic [20:0]        i_piled_array,
    output logic               o_valid,
    output logic               o_finished,
    output logic signed [15:0] o_score,
    output logic [2:0]         o_selected_col
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic [41:0] M_LO = {6{7'b0001111}};
    localparam logic [41:0] M_HI = {6{7'b1111000}};

    function automatic logic has_four(input logic [41:0] b);
        logic [41:0] h;
        logic [41:0] v;
        logic [41:0] d1;
        logic [41:0] d2;
        h  = b & (b >> 1);
        h  = h & (h >> 2);
        v  = b & (b >> 7);
        v  = v & (v >> 14);
        d1 = b & (b >> 8);
        d1 = d1 & (d1 >> 16);
        d2 = b & (b >> 6);
        d2 = d2 & (d2 >> 12);
        return (|(h & M_LO)) || (|v) ||
               (|(d1 & M_LO)) || (|(d2 & M_HI));
    endfunction

    state_t state;
    state_t state_n;

    logic [41:0]        me_r;
    logic [41:0]        op_r;
    logic [20:0]        piled_r;
    logic [2:0]         col;
    logic signed [15:0] best;
    logic [2:0]         best_col;
    logic               found;

    logic               child_en;
    logic [41:0]        ch_me;
    logic [41:0]        ch_op;
    logic [20:0]        ch_piled;
    logic               ch_valid;
    logic               ch_finished;
    logic signed [15:0] ch_score;

    logic [2:0]         h;
    logic               full;
    logic               last;
    logic [5:0]         pos;
    logic [41:0]        placed;
    logic [20:0]        piled_n;
    logic               win;

    logic               take;
    logic               descend;
    logic signed [15:0] cand;
    logic               better;

    always_comb begin
        h       = piled_r[col*3 +: 3];
        full    = (h >= 3'd6);
        last    = (col == 3'd6);
        pos     = {3'b000, h} * 6'd7 + {3'b000, col};
        placed  = (IS_ME ? me_r : op_r) | (42'd1 << pos);
        piled_n = piled_r;
        piled_n[col*3 +: 3] = h + 3'd1;
        win     = has_four(placed);
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        descend = 1'b0;
        cand    = '0;
        unique case (state)
            IDLE: begin
                if (w_en)
                    state_n = SCAN;
            end
            SCAN: begin
                if (full) begin
                    state_n = last ? DONE : SCAN;
                end else if (win) begin
                    take    = 1'b1;
                    cand    = IS_ME ? 16'sd1000 : -16'sd1000;
                    state_n = last ? DONE : SCAN;
                end else if (DEPTH == 1) begin
                    take    = 1'b1;
                    state_n = last ? DONE : SCAN;
                end else begin
                    descend = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (ch_finished) begin
                    take    = 1'b1;
                    cand    = ch_valid ? ch_score : '0;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                state_n = last ? DONE : SCAN;
            end
            DONE: begin
                if (o_finished && !w_en)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        better = !found || (IS_ME ? (cand > best) : (cand < best));
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state          <= IDLE;
            me_r           <= '0;
            op_r           <= '0;
            piled_r        <= '0;
            col            <= '0;
            best           <= '0;
            best_col       <= '0;
            found          <= 1'b0;
            child_en       <= 1'b0;
            ch_me          <= '0;
            ch_op          <= '0;
            ch_piled       <= '0;
            o_valid        <= 1'b0;
            o_finished     <= 1'b0;
            o_score        <= '0;
            o_selected_col <= '0;
        end else begin
            state <= state_n;
            if (take && better) begin
                best     <= cand;
                best_col <= col;
                found    <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (w_en) begin
                        me_r           <= i_me_field;
                        op_r           <= i_op_field;
                        piled_r        <= i_piled_array;
                        col            <= '0;
                        best           <= '0;
                        best_col       <= '0;
                        found          <= 1'b0;
                        o_valid        <= 1'b0;
                        o_finished     <= 1'b0;
                        o_score        <= '0;
                        o_selected_col <= '0;
                    end
                end
                SCAN: begin
                    if (descend) begin
                        ch_me    <= IS_ME ? placed : me_r;
                        ch_op    <= IS_ME ? op_r : placed;
                        ch_piled <= piled_n;
                        child_en <= 1'b1;
                    end else if (!last) begin
                        col <= col + 3'd1;
                    end
                end
                WAIT: begin
                    if (ch_finished)
                        child_en <= 1'b0;
                end
                NEXT: begin
                    if (!last)
                        col <= col + 3'd1;
                end
                DONE: begin
                    // finished is shown for at least one cycle even if w_en already fell
                    if (!o_finished) begin
                        o_finished     <= 1'b1;
                        o_valid        <= found;
                        o_score        <= best;
                        o_selected_col <= best_col;
                    end else if (!w_en) begin
                        o_finished <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    if (DEPTH > 1) begin : g_child
        logic [2:0] unused_ch_col;
        game_tree_v2 #(
            .IS_ME(!IS_ME),
            .DEPTH(DEPTH - 1)
        ) u_child (
            .w_clk         (w_clk),
            .w_rst         (w_rst),
            .w_en          (child_en),
            .i_me_field    (ch_me),
            .i_op_field    (ch_op),
            .i_piled_array (ch_piled),
            .o_valid       (ch_valid),
            .o_finished    (ch_finished),
            .o_score       (ch_score),
            .o_selected_col(unused_ch_col)
        );
    end else begin : g_leaf
        logic unused_child;
        assign unused_child = ^{child_en, ch_me, ch_op, ch_piled};
        assign ch_valid     = 1'b0;
        assign ch_finished  = 1'b0;
        assign ch_score     = '0;
    end

endmodule

// File: tb/tb_game_tree_v2.sv
// Directed bench for game_tree_v2: three configurations share one board.
// a = me/depth1, b = me/depth2, c = op/depth1.
module tb_game_tree_v2;

    logic w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic        w_rst;
    logic        w_en;
    logic [41:0] me;
    logic [41:0] op;
    logic [20:0] piled;

    logic               a_v, a_f, b_v, b_f, c_v, c_f;
    logic signed [15:0] a_s, b_s, c_s;
    logic [2:0]         a_c, b_c, c_c;

    int total = 0;
    int bad   = 0;

    game_tree_v2 #(.IS_ME(1'b1), .DEPTH(1)) u_a (
        .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en),
        .i_me_field(me), .i_op_field(op), .i_piled_array(piled),
        .o_valid(a_v), .o_finished(a_f), .o_score(a_s), .o_selected_col(a_c)
    );

    game_tree_v2 #(.IS_ME(1'b1), .DEPTH(2)) u_b (
        .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en),
        .i_me_field(me), .i_op_field(op), .i_piled_array(piled),
        .o_valid(b_v), .o_finished(b_f), .o_score(b_s), .o_selected_col(b_c)
    );

    game_tree_v2 #(.IS_ME(1'b0), .DEPTH(1)) u_c (
        .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en),
        .i_me_field(me), .i_op_field(op), .i_piled_array(piled),
        .o_valid(c_v), .o_finished(c_f), .o_score(c_s), .o_selected_col(c_c)
    );

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic set_base();
        me    = (42'd1 << 0) | (42'd1 << 7);
        op    = (42'd1 << 1) | (42'd1 << 8) | (42'd1 << 15);
        piled = 21'd26;
    endtask

    task automatic set_three();
        me    = (42'd1 << 0) | (42'd1 << 7) | (42'd1 << 14);
        op    = '0;
        piled = 21'd3;
    endtask

    task automatic wait_all(input string tag);
        int n = 0;
        while (!(a_f && b_f && c_f) && n < 1000) begin
            tick();
            n++;
        end
        total++;
        if (!(a_f && b_f && c_f)) begin
            bad++;
            $display("FAIL %s timeout: finished a=%0b b=%0b c=%0b, want 111",
                     tag, a_f, b_f, c_f);
        end
    endtask

    task automatic test_reset();
        w_rst = 1'b0;
        w_en  = 1'b0;
        me    = '0;
        op    = '0;
        piled = '0;
        repeat (2) tick();
        total++;
        if ({a_v, a_f, a_s, a_c} !== 21'd0) begin
            bad++;
            $display("FAIL reset_a got %h want 0", {a_v, a_f, a_s, a_c});
        end
        total++;
        if ({b_v, b_f, b_s, b_c} !== 21'd0) begin
            bad++;
            $display("FAIL reset_b got %h want 0", {b_v, b_f, b_s, b_c});
        end
        total++;
        if ({c_v, c_f, c_s, c_c} !== 21'd0) begin
            bad++;
            $display("FAIL reset_c got %h want 0", {c_v, c_f, c_s, c_c});
        end
        @(negedge w_clk);
        w_rst = 1'b1;
    endtask

    task automatic test_base();
        set_base();
        w_en = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (a_f !== (k == 8)) begin
                bad++;
                $display("FAIL latency_a edge %0d got %0b want %0b",
                         k, a_f, (k == 8));
            end
        end
        total++;
        if (c_f !== 1'b1) begin
            bad++;
            $display("FAIL latency_c got %0b want 1", c_f);
        end
        wait_all("base");
        total++;
        if (a_v !== 1'b1 || a_c !== 3'd0 || a_s !== 16'sd0) begin
            bad++;
            $display("FAIL base_a got v=%0b col=%0d score=%0d want 1 0 0",
                     a_v, a_c, a_s);
        end
        total++;
        if (b_v !== 1'b1 || b_c !== 3'd1 || b_s !== 16'sd0) begin
            bad++;
            $display("FAIL base_b got v=%0b col=%0d score=%0d want 1 1 0",
                     b_v, b_c, b_s);
        end
        total++;
        if (c_v !== 1'b1 || c_c !== 3'd1 || c_s !== -16'sd1000) begin
            bad++;
            $display("FAIL base_c got v=%0b col=%0d score=%0d want 1 1 -1000",
                     c_v, c_c, c_s);
        end
    endtask

    task automatic test_hold();
        set_three();
        repeat (20) tick();
        total++;
        if (a_f !== 1'b1 || b_f !== 1'b1 || c_f !== 1'b1) begin
            bad++;
            $display("FAIL hold_fin got %0b%0b%0b want 111", a_f, b_f, c_f);
        end
        total++;
        if (b_c !== 3'd1 || b_s !== 16'sd0 || c_s !== -16'sd1000) begin
            bad++;
            $display("FAIL hold_out got b=%0d/%0d c=%0d want 1/0 -1000",
                     b_c, b_s, c_s);
        end
    endtask

    task automatic test_restart();
        w_en = 1'b0;
        tick();
        total++;
        if (a_f !== 1'b0 || b_f !== 1'b0 || c_f !== 1'b0) begin
            bad++;
            $display("FAIL release got %0b%0b%0b want 000", a_f, b_f, c_f);
        end
        set_three();
        w_en = 1'b1;
        tick();
        wait_all("restart");
        total++;
        if (a_v !== 1'b1 || a_c !== 3'd0 || a_s !== 16'sd1000) begin
            bad++;
            $display("FAIL win_a got v=%0b col=%0d score=%0d want 1 0 1000",
                     a_v, a_c, a_s);
        end
        total++;
        if (b_v !== 1'b1 || b_c !== 3'd0 || b_s !== 16'sd1000) begin
            bad++;
            $display("FAIL win_b got v=%0b col=%0d score=%0d want 1 0 1000",
                     b_v, b_c, b_s);
        end
        total++;
        if (c_v !== 1'b1 || c_c !== 3'd0 || c_s !== 16'sd0) begin
            bad++;
            $display("FAIL win_c got v=%0b col=%0d score=%0d want 1 0 0",
                     c_v, c_c, c_s);
        end
    endtask

    task automatic test_async_reset();
        #2 w_rst = 1'b0;
        #1;
        total++;
        if ({a_v, a_f, a_s, a_c} !== 21'd0) begin
            bad++;
            $display("FAIL areset_a got %h want 0", {a_v, a_f, a_s, a_c});
        end
        total++;
        if ({b_v, b_f, b_s, b_c} !== 21'd0) begin
            bad++;
            $display("FAIL areset_b got %h want 0", {b_v, b_f, b_s, b_c});
        end
        w_en = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b1;
    endtask

    task automatic test_full();
        me    = '0;
        op    = '0;
        piled = {7{3'd6}};
        w_en  = 1'b1;
        tick();
        wait_all("full");
        total++;
        if ({a_v, a_s, a_c} !== 20'd0 || {b_v, b_s, b_c} !== 20'd0) begin
            bad++;
            $display("FAIL full_ab got a=%h b=%h want 0 0",
                     {a_v, a_s, a_c}, {b_v, b_s, b_c});
        end
        total++;
        if ({c_v, c_s, c_c} !== 20'd0) begin
            bad++;
            $display("FAIL full_c got %h want 0", {c_v, c_s, c_c});
        end
    endtask

    task automatic test_reset_mid_scan();
        w_en = 1'b0;
        tick();
        set_base();
        w_en = 1'b1;
        tick();
        repeat (2) tick();
        #2 w_rst = 1'b0;
        #1;
        total++;
        if ({a_v, a_f, a_s, a_c} !== 21'd0 || {c_v, c_f, c_s, c_c} !== 21'd0) begin
            bad++;
            $display("FAIL midreset got a=%h c=%h want 0 0",
                     {a_v, a_f, a_s, a_c}, {c_v, c_f, c_s, c_c});
        end
        w_en = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b1;
        repeat (15) tick();
        total++;
        if (a_f !== 1'b0 || b_f !== 1'b0 || c_f !== 1'b0) begin
            bad++;
            $display("FAIL abort got %0b%0b%0b want 000", a_f, b_f, c_f);
        end
    endtask

    initial begin
        test_reset();
        test_base();
        test_hold();
        test_restart();
        test_async_reset();
        test_full();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
